// File: rtl/clkdiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clkdiv_ctrl
// Purpose  : Run/stop controller for a programmable clock divider. Produces a
//            divided square wave and a tick pulse, and applies new divide
//            values only at full-period boundaries so no runt pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl #(
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 49999999,
    parameter int MIN_DIV = 1,
    parameter int TCNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Stop,
    input  logic              CfgValid,
    input  logic [CNT_W-1:0]  CfgDiv,
    output logic              CfgReady,
    output logic              ClkOut,
    output logic              Tick,
    output logic              Running,
    output logic [CNT_W-1:0]  CurDiv,
    output logic [TCNT_W-1:0] TickCnt
);

    localparam logic [CNT_W-1:0] c_defDiv = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_minDiv = CNT_W'(MIN_DIV);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;

    logic             w_accept;
    logic             w_tc;
    logic [CNT_W-1:0] w_cfgVal;

    assign CfgReady = ~r_pend;
    assign w_accept = CfgValid & ~r_pend;
    assign w_tc     = (r_cnt == CurDiv);
    assign w_cfgVal = (CfgDiv < c_minDiv) ? c_minDiv : CfgDiv;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            ClkOut   <= 1'b0;
            Tick     <= 1'b0;
            Running  <= 1'b0;
            CurDiv   <= c_defDiv;
            TickCnt  <= '0;
        end else begin
            Tick    <= 1'b0;
            Running <= (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    ClkOut <= 1'b0;
                    if (w_accept) begin
                        CurDiv <= w_cfgVal;
                    end
                    if (Start && !Stop) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_shadow <= w_cfgVal;
                        r_pend   <= 1'b1;
                    end
                    if (w_tc) begin
                        r_cnt   <= '0;
                        ClkOut  <= ~ClkOut;
                        Tick    <= 1'b1;
                        TickCnt <= TickCnt + TCNT_W'(1);
                        // Only the falling edge closes a full period.
                        if (ClkOut && r_pend) begin
                            CurDiv <= r_shadow;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (Stop) begin
                        if (!ClkOut && !w_tc) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (w_tc) begin
                        r_cnt   <= '0;
                        ClkOut  <= 1'b0;
                        Tick    <= 1'b1;
                        TickCnt <= TickCnt + TCNT_W'(1);
                        r_state <= IDLE;
                        if (r_pend) begin
                            CurDiv <= r_shadow;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
